// File: rtl/rv32_single_cycle_cpu.sv
// rv32_single_cycle_cpu: one-instruction-per-clock RV32I subset core
// with a built-in program ROM, 32x32 register file and word RAM.
module rv32_single_cycle_cpu #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_zf,
  output logic        io_of,
  output logic [31:0] io_aluResult,
  output logic [31:0] io_currentInst,
  output logic [31:0] io_currentPC,
  output logic        io_isSignedOp,
  output logic        io_dmemWen,
  output logic [31:0] io_dmemAddr,
  output logic [31:0] io_dmemWData,
  output logic [31:0] io_dmemRData
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_OP  = 7'h33;
  localparam logic [6:0] OPC_OPI = 7'h13;
  localparam logic [6:0] OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLL,
    A_SRL, A_SRA, A_SLT, A_SLTU, A_PASS
  } alu_op_e;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_u;
  logic [31:0] opb, alu, sum, diff, wb_data;
  logic [DW-1:0] dmem_idx;
  alu_op_e     op;
  logic        valid, wr_en, load, store;

  function automatic logic [31:0] rom(input int i);
    case (i)
      0:  return 32'hfff00093;
      1:  return 32'h08102023;
      2:  return 32'h08002103;
      3:  return 32'hff810113;
      4:  return 32'h08202223;
      5:  return 32'h08402183;
      6:  return 32'h08002203;
      7:  return 32'h876542b7;
      8:  return 32'h32128293;
      9:  return 32'h10502023;
      10: return 32'h10002303;
      default: return 32'h00000013;
    endcase
  endfunction

  function automatic alu_op_e dec(
    input logic [2:0] f,
    input logic       a
  );
    case (f)
      3'd0:    return a ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd3:    return A_SLTU;
      3'd4:    return A_XOR;
      3'd5:    return a ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  assign inst   = rom(int'(pc[IW+1:2]));
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign alt    = inst[30];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u = {inst[31:12], 12'h000};

  assign rs1_v = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  always_comb begin
    op    = A_ADD;
    opb   = imm_i;
    valid = 1'b0;
    wr_en = 1'b0;
    load  = 1'b0;
    store = 1'b0;
    unique case (1'b1)
      opcode == OPC_OP: begin
        op    = dec(f3, alt);
        opb   = rs2_v;
        valid = 1'b1;
        wr_en = 1'b1;
      end
      opcode == OPC_OPI: begin
        // bit 30 of an I-imm only selects srai; addi never becomes sub
        op    = dec(f3, (f3 == 3'd5) && alt);
        valid = 1'b1;
        wr_en = 1'b1;
      end
      opcode == OPC_LUI: begin
        op    = A_PASS;
        opb   = imm_u;
        valid = 1'b1;
        wr_en = 1'b1;
      end
      opcode == OPC_LD: begin
        valid = 1'b1;
        wr_en = 1'b1;
        load  = 1'b1;
      end
      opcode == OPC_ST: begin
        opb   = imm_s;
        valid = 1'b1;
        store = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = rs1_v + opb;
  assign diff = rs1_v - opb;

  always_comb begin
    alu = sum;
    case (op)
      A_ADD:  alu = sum;
      A_SUB:  alu = diff;
      A_AND:  alu = rs1_v & opb;
      A_OR:   alu = rs1_v | opb;
      A_XOR:  alu = rs1_v ^ opb;
      A_SLL:  alu = rs1_v << opb[4:0];
      A_SRL:  alu = rs1_v >> opb[4:0];
      A_SRA:  alu = 32'($signed(rs1_v) >>> opb[4:0]);
      A_SLT:  alu = {31'h0, $signed(rs1_v) < $signed(opb)};
      A_SLTU: alu = {31'h0, rs1_v < opb};
      A_PASS: alu = opb;
      default: alu = sum;
    endcase
  end

  always_comb begin
    io_of = 1'b0;
    if (valid && op == A_ADD)
      io_of = (rs1_v[31] == opb[31]) && (sum[31] != rs1_v[31]);
    else if (valid && op == A_SUB)
      io_of = (rs1_v[31] != opb[31]) && (diff[31] != rs1_v[31]);
  end

  assign io_isSignedOp = valid && !load && !store &&
                         (op inside {A_ADD, A_SUB, A_SLT, A_SRA});

  assign io_zf          = (alu == 32'h0);
  assign io_aluResult   = alu;
  assign io_currentInst = inst;
  assign io_currentPC   = pc;
  assign io_dmemAddr    = alu;
  assign io_dmemWData   = rs2_v;
  assign io_dmemWen     = store && reset;

  assign dmem_idx     = alu[DW+1:2];
  assign io_dmemRData = dmem[dmem_idx];
  assign wb_data      = load ? io_dmemRData : alu;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc + 32'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wr_en && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clock) begin
    if (io_dmemWen) dmem[dmem_idx] <= io_dmemWData;
  end
endmodule

// File: tb/tb_rv32_single_cycle_cpu.sv
// tb_rv32_single_cycle_cpu: ISA-level reference model with random
// asynchronous resets plus hand-computed program expectations.
module tb_rv32_single_cycle_cpu;
  logic        clock;
  logic        reset;
  logic        io_zf, io_of, io_isSignedOp, io_dmemWen;
  logic [31:0] io_aluResult, io_currentInst, io_currentPC;
  logic [31:0] io_dmemAddr, io_dmemWData, io_dmemRData;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [256];
  logic        m_wr  [256];
  logic [31:0] m_rom [64];

  rv32_single_cycle_cpu dut (
    .clock          (clock),
    .reset          (reset),
    .io_zf          (io_zf),
    .io_of          (io_of),
    .io_aluResult   (io_aluResult),
    .io_currentInst (io_currentInst),
    .io_currentPC   (io_currentPC),
    .io_isSignedOp  (io_isSignedOp),
    .io_dmemWen     (io_dmemWen),
    .io_dmemAddr    (io_dmemAddr),
    .io_dmemWData   (io_dmemWData),
    .io_dmemRData   (io_dmemRData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Architectural meaning of one instruction given its source values
  function automatic void mexec(
    input  logic [31:0] in, a, b,
    output logic [31:0] r,
    output logic o, s, st, wb, ld
  );
    logic [31:0] ii, si, bb;
    ii = {{20{in[31]}}, in[31:20]};
    si = {{20{in[31]}}, in[31:25], in[11:7]};
    r = 0; o = 0; s = 0; st = 0; wb = 0; ld = 0;
    case (in[6:0])
      7'h13, 7'h33: begin
        bb = in[5] ? b : ii;
        wb = 1;
        case (in[14:12])
          3'd0: begin
            s = 1;
            if (in[5] && in[30]) begin
              r = a - bb;
              o = (a[31] != bb[31]) && (r[31] != a[31]);
            end else begin
              r = a + bb;
              o = (a[31] == bb[31]) && (r[31] != a[31]);
            end
          end
          3'd1: r = a << bb[4:0];
          3'd2: begin r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0; s = 1; end
          3'd3: r = (a < bb) ? 32'd1 : 32'd0;
          3'd4: r = a ^ bb;
          3'd5: begin
            if (in[30]) begin r = 32'($signed(a) >>> bb[4:0]); s = 1; end
            else r = a >> bb[4:0];
          end
          3'd6: r = a | bb;
          default: r = a & bb;
        endcase
      end
      7'h37: begin r = {in[31:12], 12'h0}; wb = 1; end
      7'h03: begin
        r = a + ii; wb = 1; ld = 1;
        o = (a[31] == ii[31]) && (r[31] != a[31]);
      end
      7'h23: begin
        r = a + si; st = 1;
        o = (a[31] == si[31]) && (r[31] != a[31]);
      end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  logic [31:0] e_inst, e_r;
  logic        e_o, e_s, e_st, e_wb, e_ld;

  always @(negedge clock) begin
    e_inst = m_rom[m_pc[7:2]];
    mexec(e_inst, m_rf[e_inst[19:15]], m_rf[e_inst[24:20]],
          e_r, e_o, e_s, e_st, e_wb, e_ld);
    chk("pc", io_currentPC, m_pc);
    chk("inst", io_currentInst, e_inst);
    chk("alu", io_aluResult, e_r);
    chk("zf", 32'(io_zf), 32'(e_r == 0));
    chk("of", 32'(io_of), 32'(e_o));
    chk("signed", 32'(io_isSignedOp), 32'(e_s));
    chk("wen", 32'(io_dmemWen), 32'(e_st && reset));
    chk("addr", io_dmemAddr, e_r);
    chk("wdata", io_dmemWData, m_rf[e_inst[24:20]]);
    if (m_wr[e_r[9:2]]) chk("rdata", io_dmemRData, m_mem[e_r[9:2]]);
  end

  logic [31:0] s_inst, s_r, s_b;
  logic        s_o, s_s, s_st, s_wb, s_ld;

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      s_inst = m_rom[m_pc[7:2]];
      s_b    = m_rf[s_inst[24:20]];
      mexec(s_inst, m_rf[s_inst[19:15]], s_b,
            s_r, s_o, s_s, s_st, s_wb, s_ld);
      if (s_wb && s_inst[11:7] != 0)
        m_rf[s_inst[11:7]] = s_ld ? m_mem[s_r[9:2]] : s_r;
      if (s_st) begin
        m_mem[s_r[9:2]] = s_b;
        m_wr[s_r[9:2]]  = 1;
      end
      m_pc = m_pc + 4;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) m_rom[i] = 32'h00000013;
    m_rom[0]  = 32'hfff00093; m_rom[1]  = 32'h08102023;
    m_rom[2]  = 32'h08002103; m_rom[3]  = 32'hff810113;
    m_rom[4]  = 32'h08202223; m_rom[5]  = 32'h08402183;
    m_rom[6]  = 32'h08002203; m_rom[7]  = 32'h876542b7;
    m_rom[8]  = 32'h32128293; m_rom[9]  = 32'h10502023;
    m_rom[10] = 32'h10002303;
    for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_wr[i] = 0; end
    model_reset();
    reset = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_pc", io_currentPC, 32'h0);
    chk("rst_inst", io_currentInst, 32'hfff00093);
    chk("rst_wen", 32'(io_dmemWen), 32'h0);

    @(posedge clock); #2 reset = 1'b1;

    for (int c = 0; c < 66; c++) begin
      @(negedge clock);
      chk("lit_pc", io_currentPC, 32'(c * 4));
      case (c)
        0, 64: begin
          chk("lit_alu", io_aluResult, 32'hffffffff);
          chk("lit_zf", 32'(io_zf), 32'h0);
        end
        1, 65: begin
          chk("lit_wen", 32'(io_dmemWen), 32'h1);
          chk("lit_addr", io_dmemAddr, 32'h00000080);
          chk("lit_wdata", io_dmemWData, 32'hffffffff);
        end
        2: chk("lit_rdata", io_dmemRData, 32'hffffffff);
        3: chk("lit_alu", io_aluResult, 32'hfffffff7);
        4: begin
          chk("lit_addr", io_dmemAddr, 32'h00000084);
          chk("lit_wdata", io_dmemWData, 32'hfffffff7);
        end
        5: chk("lit_rdata", io_dmemRData, 32'hfffffff7);
        6: chk("lit_rdata", io_dmemRData, 32'hffffffff);
        7: chk("lit_alu", io_aluResult, 32'h87654000);
        8: chk("lit_alu", io_aluResult, 32'h87654321);
        9: begin
          chk("lit_addr", io_dmemAddr, 32'h00000100);
          chk("lit_wdata", io_dmemWData, 32'h87654321);
        end
        10: chk("lit_rdata", io_dmemRData, 32'h87654321);
        11: begin
          chk("lit_alu", io_aluResult, 32'h0);
          chk("lit_zf", 32'(io_zf), 32'h1);
          chk("lit_wen", 32'(io_dmemWen), 32'h0);
        end
        default: ;
      endcase
    end

    for (int i = 0; i < 900; i++) begin
      @(posedge clock); #2;
      if (reset && $urandom_range(0, 99) < 2) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_pc", io_currentPC, 32'h0);
        chk("async_inst", io_currentInst, 32'hfff00093);
      end else if (!reset && $urandom_range(0, 2) == 0) begin
        reset = 1'b1;
      end
    end

    @(posedge clock); #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
